// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU core and its iterative divider.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam logic [ALU_WIDTH-1:0] INT_MIN = {1'b1, {(ALU_WIDTH-1){1'b0}}};
    localparam logic [ALU_WIDTH-1:0] INT_MAX = {1'b0, {(ALU_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_ILL = 3'b111
    } opcode_e;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } state_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] A;
        logic [ALU_WIDTH-1:0] B;
        opcode_e              opcode;
    } alu_req_t;

    // Signed add overflow from sign bits; for subtraction pass the inverted B sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_div_seq.sv
// Iterative restoring divider on unsigned magnitudes, DIV_STEPS quotient bits per cycle.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int N_STEPS = WIDTH / DIV_STEPS;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] quo_s;

    // One cycle of restoring division: shift dividend bits into the remainder, subtract when it fits.
    always_comb begin
        rem_s = {1'b0, rem_r};
        quo_s = quo_r;
        for (int i = 0; i < DIV_STEPS; i++) begin
            rem_s = {rem_s[WIDTH-1:0], quo_s[WIDTH-1]};
            quo_s = {quo_s[WIDTH-2:0], 1'b0};
            if (rem_s >= {1'b0, div_r}) begin
                rem_s    = rem_s - {1'b0, div_r};
                quo_s[0] = 1'b1;
            end else begin
                rem_s = rem_s;
            end
        end
    end

    // The quotient handed out with done is the result of the step taken on that same edge.
    assign done     = busy_r && (cnt_r == LAST_C);
    assign quotient = quo_s;

    // Step counter, partial remainder and dividend/quotient shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            div_r  <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= {CNT_W{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            quo_r  <= dividend;
            div_r  <= divisor;
        end else if (busy_r) begin
            rem_r  <= rem_s[WIDTH-1:0];
            quo_r  <= quo_s;
            cnt_r  <= cnt_r + CNT_ONE_C;
            busy_r <= !done;
        end
    end

endmodule

// File: rtl/alu_core_seq.sv
// Handshaked signed ALU: single-cycle ops answer next cycle, DIV stalls on an iterative divider.
module alu_core_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic             Error
);

    localparam logic [WIDTH-1:0] MIN_C  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_r;
    state_e                  state_s;
    opcode_e                 op_s;
    logic                    accept_s;
    logic                    div_special_s;
    logic                    div_start_s;
    logic                    div_done_s;
    logic                    neg_q_r;
    logic [WIDTH-1:0]        a_mag_s;
    logic [WIDTH-1:0]        b_mag_s;
    logic [WIDTH-1:0]        quo_s;
    logic [WIDTH-1:0]        sum_s;
    logic [WIDTH-1:0]        diff_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]        res_s;
    logic                    err_s;
    logic                    out_valid_r;
    logic [WIDTH-1:0]        result_r;
    logic                    error_r;

    assign op_s          = opcode_e'(opcode);
    assign in_ready      = (state_r == IDLE) && !rst;
    assign accept_s      = in_valid && in_ready;
    assign div_special_s = (B == ZERO_C) || ((A == MIN_C) && (B == ONES_C));
    assign div_start_s   = accept_s && (op_s == OP_DIV) && !div_special_s;
    assign a_mag_s       = A[WIDTH-1] ? (~A + ONE_C) : A;
    assign b_mag_s       = B[WIDTH-1] ? (~B + ONE_C) : B;
    assign sum_s         = A + B;
    assign diff_s        = A - B;
    assign prod_s        = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});

    alu_div_seq #(
        .WIDTH     (WIDTH),
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (a_mag_s),
        .divisor  (b_mag_s),
        .done     (div_done_s),
        .quotient (quo_s)
    );

    // Single-cycle result and error; the DIV arm only covers the resolved-at-accept cases.
    always_comb begin
        res_s = ZERO_C;
        err_s = 1'b0;
        case (op_s)
            OP_ADD: begin
                res_s = sum_s;
                err_s = signed_ovf(A[WIDTH-1], B[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                res_s = diff_s;
                err_s = signed_ovf(A[WIDTH-1], !B[WIDTH-1], diff_s[WIDTH-1]);
            end
            OP_MUL: begin
                res_s = prod_s[WIDTH-1:0];
                err_s = (prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
                        (prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
            end
            OP_DIV: begin
                res_s = (B == ZERO_C) ? ZERO_C : MIN_C;
                err_s = 1'b1;
            end
            OP_AND: res_s = A & B;
            OP_OR:  res_s = A | B;
            OP_XOR: res_s = A ^ B;
            OP_ILL: begin
                res_s = ZERO_C;
                err_s = 1'b1;
            end
            default: begin
                res_s = ZERO_C;
                err_s = 1'b1;
            end
        endcase
    end

    // Next-state: only a normal DIV leaves IDLE, and the divider's last step returns it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_start_s) state_s = DIV_RUN;
                else             state_s = IDLE;
            end
            DIV_RUN: begin
                if (div_done_s) state_s = IDLE;
                else            state_s = DIV_RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Quotient sign is fixed at accept so later operand changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst)              neg_q_r <= 1'b0;
        else if (div_start_s) neg_q_r <= A[WIDTH-1] ^ B[WIDTH-1];
    end

    // Output registers: a strobe per completed op, values held between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= ZERO_C;
            error_r     <= 1'b0;
        end else if ((state_r == DIV_RUN) && div_done_s) begin
            out_valid_r <= 1'b1;
            result_r    <= neg_q_r ? (~quo_s + ONE_C) : quo_s;
            error_r     <= 1'b0;
        end else if (accept_s && !div_start_s) begin
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            error_r     <= err_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign Result    = result_r;
    assign Error     = error_r;

endmodule

// File: tb/tb_alu_core_seq.sv
// Self-checking bench for alu_core_seq: directed vector table, handshake corner sequences, random vs model.
module tb_alu_core_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opcode;
    logic        out_valid;
    logic [31:0] result;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    alu_core_seq #(.WIDTH(32), .DIV_STEPS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .Result    (result),
        .Error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // Reference model written from the arithmetic rules using 64-bit signed math.
    function automatic void model(input logic [2:0] op, input logic [31:0] ua, input logic [31:0] ub,
                                  output logic [31:0] r, output logic e, output int lat);
        longint sa = longint'($signed(ua));
        longint sb = longint'($signed(ub));
        longint x;
        longint lo = -(64'sd1 <<< 31);
        longint hi = (64'sd1 <<< 31) - 64'sd1;
        lat = 1;
        e   = 1'b0;
        r   = 32'h0;
        case (op)
            3'd0: begin x = sa + sb; r = x[31:0]; e = (x < lo) || (x > hi); end
            3'd1: begin x = sa - sb; r = x[31:0]; e = (x < lo) || (x > hi); end
            3'd2: begin x = sa * sb; r = x[31:0]; e = (x < lo) || (x > hi); end
            3'd3: begin
                if (sb == 0) begin
                    r = 32'h0; e = 1'b1;
                end else if (sa == lo && sb == -1) begin
                    r = 32'h8000_0000; e = 1'b1;
                end else begin
                    x = sa / sb; r = x[31:0]; e = 1'b0; lat = 33;
                end
            end
            3'd4: r = ua & ub;
            3'd5: r = ua | ub;
            3'd6: r = ua ^ ub;
            default: begin r = 32'h0; e = 1'b1; end
        endcase
    endfunction

    // Issue one request, wait for accept and for the out_valid strobe, then check latency and outputs.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_r, input logic exp_e, input int exp_lat);
        int waited = 0;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = va; b = vb;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk({name, ".accept"}, 32'(in_ready), 32'h1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            chk({name, ".lat"}, 32'(lat), 32'(exp_lat));
            chk({name, ".res"}, result, exp_r);
            chk({name, ".err"}, 32'(error), 32'(exp_e));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[16];

    initial begin
        logic [31:0] mr;
        logic        me;
        int          ml;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        int          bad;
        int          seen;

        vecs[0]  = '{"add_ovf_pos", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1};
        vecs[1]  = '{"add_ovf_neg", 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1};
        vecs[2]  = '{"add_plain",   3'd0, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 1'b0, 1};
        vecs[3]  = '{"sub_plain",   3'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1};
        vecs[4]  = '{"sub_ovf",     3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1};
        vecs[5]  = '{"mul_ovf",     3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1};
        vecs[6]  = '{"mul_neg",     3'd2, 32'hFFFF_FFFD, 32'h0000_0004, 32'hFFFF_FFF4, 1'b0, 1};
        vecs[7]  = '{"div_by0",     3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[8]  = '{"div_minm1",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1};
        vecs[9]  = '{"div_m100_7",  3'd3, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0, 33};
        vecs[10] = '{"div_7_m2",    3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[11] = '{"div_min_2",   3'd3, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0, 33};
        vecs[12] = '{"and",         3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[13] = '{"or",          3'd5, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1};
        vecs[14] = '{"xor",         3'd6, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 1};
        vecs[15] = '{"illegal",     3'd7, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};

        rst = 1'b1; in_valid = 1'b0; a = 32'h0; b = 32'h0; opcode = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.res", result, 32'h0);
        chk("rst.err", 32'(error), 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.release_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 16; i++)
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, vecs[i].lat);

        // Back-to-back accepts: ADD then SUB on the following edge.
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'd0; a = 32'h7FFF_FFFF; b = 32'h0000_0001;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.add_valid", 32'(out_valid), 32'h1);
        chk("b2b.add_res", result, 32'h8000_0000);
        chk("b2b.add_err", 32'(error), 32'h1);
        opcode = 3'd1; a = 32'd5; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b.sub_valid", 32'(out_valid), 32'h1);
        chk("b2b.sub_res", result, 32'hFFFF_FFFE);
        chk("b2b.sub_err", 32'(error), 32'h0);

        // DIV busy window: a different request held during the stall is taken only in the done cycle.
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'd3; a = 32'hFFFF_FF9C; b = 32'd7;
        @(posedge clk); #1;
        opcode = 3'd0; a = 32'd2; b = 32'd3;
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("div_busy.stall_cycles", 32'(bad), 32'h0);
        chk("div_busy.valid", 32'(out_valid), 32'h1);
        chk("div_busy.res", result, 32'hFFFF_FFF2);
        chk("div_busy.err", 32'(error), 32'h0);
        chk("div_busy.ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("div_busy.next_valid", 32'(out_valid), 32'h1);
        chk("div_busy.next_res", result, 32'h0000_0005);
        chk("div_busy.next_err", 32'(error), 32'h0);

        // Reset during DIV 1000/3: the aborted op never reports.
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.ready_in_rst", 32'(in_ready), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.ready", 32'(in_ready), 32'h1);
        chk("abort.valid", 32'(out_valid), 32'h0);
        chk("abort.res", result, 32'h0);
        chk("abort.err", 32'(error), 32'h0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort.no_strobe", 32'(seen), 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            model(rop, ra, rb, mr, me, ml);
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, mr, me, ml);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
